// File: rtl/neuron_input_stage.sv
// Neuron input stage: buffers IEEE-754 weights, accumulates them per timestep and leaks the membrane potential.
// Define NEURON_DECAY_EN to build the leak multiplier; without it the stored potential passes through unchanged.
module neuron_input_stage #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] DECAY_FACTOR = 32'h3F666666
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] weight_in,
  input  logic        weight_valid,
  output logic        weight_ready,
  input  logic        timestep_start,
  input  logic        timestep_end,
  input  logic [31:0] potential_in,
  input  logic        potential_valid,
  output logic [31:0] input_weight,
  output logic [31:0] decayed_potential,
  output logic        out_valid,
  output logic        busy,
  output logic        exception
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (DECAY_FACTOR[30:23] == 8'hFF)) begin : g_bad_cfg
    $error("neuron_input_stage: unsupported FIFO_DEPTH or non-finite DECAY_FACTOR");
  end

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, DECAY, OUT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop, start_accum;
  logic [31:0]       acc, potential;
  logic [32:0]       add_res;

  // Single-precision add, round-to-nearest-even; denormals flush to zero.
  // Result bit 32 flags NaN/Inf operands or overflow.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [23:0] mx0, my0;
    logic [49:0] sh;
    logic [26:0] mx, my, n;
    logic [27:0] s;
    logic [24:0] mr;
    logic        rnd;
    int          ex, d, e, lz;
    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return {1'b1, 32'h7FC00000};
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx0 = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my0 = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    ex  = int'(x[30:23]);
    d   = ex - int'(y[30:23]);
    sh  = {my0, 26'd0} >> d;
    mx  = {mx0, 3'b000};
    my  = {sh[49:24], |sh[23:0]};
    s   = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (s == 28'd0) return 33'd0;
    if (s[27]) begin
      n = {s[27:2], |s[1:0]};
      e = ex + 1;
    end else begin
      lz = 0;
      for (int i = 0; i <= 26; i++) if (s[i]) lz = 26 - i;
      n = s[26:0] << lz;
      e = ex - lz;
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[26:3]} + 25'(rnd);
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 255) return {1'b1, x[31], 8'hFF, 23'd0};
    if (e <= 0) return 33'd0;
    return {1'b0, x[31], e[7:0], mr[22:0]};
  endfunction

`ifdef NEURON_DECAY_EN
  logic [32:0] mul_res;

  // Single-precision multiply with the same rounding and exception rules as fp_add.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic [24:0] mr;
    logic        g, st, sgn;
    int          e;
    sgn = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return {1'b1, 32'h7FC00000};
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return {1'b0, sgn, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    mr = {1'b0, m} + 25'(g & (st | m[0]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 255) return {1'b1, sgn, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, sgn, 31'd0};
    return {1'b0, sgn, e[7:0], mr[22:0]};
  endfunction

  assign mul_res = fp_mul(potential, DECAY_FACTOR);
`endif

  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign weight_ready = (state == ACCUM) && !full;
  assign push         = weight_valid && weight_ready;
  assign pop          = ((state == ACCUM) || (state == DRAIN)) && !empty;
  assign out_valid    = (state == OUT);
  assign busy         = (state != IDLE);
  assign start_accum  = (state == IDLE) && timestep_start;
  assign add_res      = fp_add(acc, mem[rd_ptr]);

  // A simultaneous end pulse in IDLE is dropped because only the IDLE arm looks at timestep_start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (timestep_start) state_nxt = ACCUM;
      ACCUM:   if (timestep_end) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DECAY;
      DECAY:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= weight_in;
  end

  // Accumulate / leak stage; DECAY reads the potential as it stood before any same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc               <= '0;
      potential         <= '0;
      input_weight      <= '0;
      decayed_potential <= '0;
      exception         <= 1'b0;
    end else begin
      if (potential_valid) potential <= potential_in;
      if (start_accum) begin
        acc       <= '0;
        exception <= 1'b0;
      end else if (pop) begin
        acc <= add_res[31:0];
        if (add_res[32]) exception <= 1'b1;
      end
      if (state == DECAY) begin
        input_weight <= acc;
`ifdef NEURON_DECAY_EN
        decayed_potential <= mul_res[31:0];
        if (mul_res[32]) exception <= 1'b1;
`else
        decayed_potential <= potential;
`endif
      end
    end
  end

endmodule

// File: tb/tb_neuron_input_stage.sv
// Bench for neuron_input_stage: directed timesteps plus randomized ones against an integer-valued float model.
module tb_neuron_input_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] weight_in;
  logic        weight_valid;
  logic        weight_ready;
  logic        timestep_start;
  logic        timestep_end;
  logic [31:0] potential_in;
  logic        potential_valid;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic        out_valid;
  logic        busy;
  logic        exception;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_p    = 0;

  always #5 clk = ~clk;

  neuron_input_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .weight_in         (weight_in),
    .weight_valid      (weight_valid),
    .weight_ready      (weight_ready),
    .timestep_start    (timestep_start),
    .timestep_end      (timestep_end),
    .potential_in      (potential_in),
    .potential_valid   (potential_valid),
    .input_weight      (input_weight),
    .decayed_potential (decayed_potential),
    .out_valid         (out_valid),
    .busy              (busy),
    .exception         (exception)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Exact single-precision encoding of a small integer.
  function automatic logic [31:0] i2f(input int n);
    logic [31:0] m, f;
    int          p;
    if (n == 0) return 32'd0;
    m = 32'((n < 0) ? -n : n);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    f = m << (23 - p);
    return {(n < 0) ? 1'b1 : 1'b0, 8'(127 + p), f[22:0]};
  endfunction

  // Potentials are multiples of 10, so 0.9*p is an exact integer.
  function automatic logic [31:0] exp_decay(input int p);
`ifdef NEURON_DECAY_EN
    return i2f(p * 9 / 10);
`else
    return i2f(p);
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_potential(input int p);
    potential_in = i2f(p);
    potential_valid = 1'b1;
    tick();
    potential_valid = 1'b0;
    cur_p = p;
  endtask

  task automatic start_ts();
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
  endtask

  task automatic collect(input int w[$], input bit gaps, output int sum);
    int idx = 0;
    int guard = 0;
    sum = 0;
    while (idx < w.size() && guard < 500) begin
      weight_in = i2f(w[idx]);
      weight_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (weight_valid && weight_ready) begin
        sum += w[idx];
        idx++;
      end
      tick();
      guard++;
    end
    weight_valid = 1'b0;
    check("pushes_accepted", idx, w.size());
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_ts(input string tag, input int exp_lat, input logic [31:0] exp_w,
                           input logic [31:0] exp_d);
    int lat;
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_weight"}, input_weight, exp_w);
    check({tag, "_decay"}, decayed_potential, exp_d);
    check({tag, "_exception"}, {31'd0, exception}, 32'd0);
    tick();
    check({tag, "_pulse_once"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int sum, lat, got, cyc, hits;
    int w[$];

    rst = 1'b1;
    weight_in = '0;
    weight_valid = 1'b0;
    timestep_start = 1'b0;
    timestep_end = 1'b0;
    potential_in = '0;
    potential_valid = 1'b0;
    tick();
    check("rst_weight_ready", {31'd0, weight_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_exception", {31'd0, exception}, 32'd0);
    check("rst_input_weight", input_weight, 32'd0);
    check("rst_decayed", decayed_potential, 32'd0);
    rst = 1'b0;
    tick();

    // 1.0 + 2.0 = 3.0
    start_ts();
    check("accum_busy", {31'd0, busy}, 32'd1);
    w = '{1, 2};
    collect(w, 1'b0, sum);
    repeat (DEPTH + 1) tick();
    finish_ts("two_weights", 3, 32'h40400000, exp_decay(0));

    // Empty timestep with a leak; a potential load during DECAY must not affect this result.
    load_potential(40);
    start_ts();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    potential_in = i2f(50);
    potential_valid = 1'b1;
    tick();
    potential_valid = 1'b0;
    cur_p = 50;
    check("empty_out_valid", {31'd0, out_valid}, 32'd1);
    check("empty_decay", decayed_potential, exp_decay(40));
    check("empty_weight", input_weight, 32'd0);
    tick();
    check("empty_pulse_once", {31'd0, out_valid}, 32'd0);

    // Six back-to-back weights; end arrives with the last push, leaving one entry to drain.
    start_ts();
    weight_in = i2f(1);
    weight_valid = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 50) begin
      if (weight_ready) begin
        got++;
        if (got == 6) timestep_end = 1'b1;
      end
      tick();
      cyc++;
    end
    weight_valid = 1'b0;
    timestep_end = 1'b0;
    check("stream_cycles", cyc, 6);
    wait_out(lat);
    check("stream_latency", lat, 4);
    check("stream_weight", input_weight, 32'h40C00000);
    check("stream_decay", decayed_potential, exp_decay(cur_p));

    // End pulse in IDLE is ignored; start+end together only opens the timestep.
    tick();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    check("idle_end_ignored", {31'd0, busy}, 32'd0);
    timestep_start = 1'b1;
    timestep_end = 1'b1;
    tick();
    timestep_start = 1'b0;
    timestep_end = 1'b0;
    hits = 0;
    repeat (5) begin
      tick();
      if (out_valid) hits++;
    end
    check("start_end_same_busy", {31'd0, busy}, 32'd1);
    check("start_end_same_no_out", hits, 0);
    finish_ts("start_end_same", 3, 32'd0, exp_decay(cur_p));

    // Reset mid-timestep discards buffered weights and the pending result.
    start_ts();
    w = '{1, 1, 1};
    collect(w, 1'b0, sum);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_p = 0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, weight_ready}, 32'd0);
    hits = 0;
    repeat (6) begin
      tick();
      if (out_valid) hits++;
    end
    check("midrst_no_out", hits, 0);
    start_ts();
    w = '{2};
    collect(w, 1'b0, sum);
    repeat (DEPTH + 1) tick();
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
    finish_ts("after_rst", 3, 32'h40000000, exp_decay(0));

    // Randomized timesteps: small integer weights keep every partial sum exact.
    for (int ts = 0; ts < 10; ts++) begin
      int n;
      load_potential(int'($urandom_range(0, 20)) * 10 - 100);
      start_ts();
      n = int'($urandom_range(0, 7));
      w = {};
      for (int k = 0; k < n; k++) w.push_back(int'($urandom_range(0, 40)) - 20);
      collect(w, 1'b1, sum);
      repeat (DEPTH + 1) tick();
      finish_ts($sformatf("rand%0d", ts), 3, i2f(sum), exp_decay(cur_p));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
